fpu_arbiter: RTL and testbench
==============================

Name: fpu_arbiter

Overview:
- Shares the single `fpu` instance between NUM_REQ independent requesters using round-robin arbitration.
- Latches the winner's operands and operation, then drives the FPU start/cmd_end handshake.
- Returns the result to the owning requester with a one-cycle response pulse; a watchdog aborts hung operations.
- Sits between the CPU-side microcode/DMA ports and the FPU datapath.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- TIMEOUT_CYCLES, 1024, maximum cycles in WAIT before abort (≥4).
- NAN_VALUE, 32'h7FC00000, result returned on timeout.

Ports:
- clk  in  1  system clock.
- arst  in  1  asynchronous reset, active-low (asserted when 0).
- req  in  NUM_REQ  per-requester request, level; held until gnt.
- req_a  in  32*NUM_REQ  operand A, slice i = [32i+31:32i].
- req_b  in  32*NUM_REQ  operand B, same slicing.
- req_op  in  $bits(pa_fpu::e_fpu_op)*NUM_REQ  operation per requester.
- gnt  out  NUM_REQ  one-hot, 1-cycle pulse: operands latched.
- rsp_valid  out  NUM_REQ  one-hot, 1-cycle pulse: rsp_data valid for that requester.
- rsp_data  out  32  result (IEEE-754 single).
- rsp_err  out  1  qualifies rsp_valid: 1 = timeout abort.
- fpu_start  out  1  to fpu.start.
- fpu_a_operand  out  32  to fpu.a_operand.
- fpu_b_operand  out  32  to fpu.b_operand.
- fpu_operation  out  pa_fpu::e_fpu_op  to fpu.operation.
- fpu_result  in  32  from fpu.ieee_packet_out.
- fpu_cmd_end  in  1  from fpu.cmd_end.
- fpu_busy  in  1  from fpu.busy.
- arb_busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (arst=0, async) forces:
  - outputs: gnt, rsp_valid, rsp_err, fpu_start, arb_busy = 0; fpu_a_operand, fpu_b_operand, rsp_data = 0; fpu_operation = op 0.
  - internal: state = IDLE; rr pointer last = NUM_REQ-1, so requester 0 has first priority; watchdog = 0; cmd_end edge register = 0.
- Reset mid-operation: fpu_start drops immediately and the in-flight op is discarded with no rsp_valid.
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - Issues if |req && !fpu_busy && !fpu_cmd_end.
  - Winner = first asserted req scanning last+1, last+2, … modulo NUM_REQ.
  - Same edge: latch that requester's a/b/op into fpu_* regs, record owner, gnt[owner]=1 for one cycle, go to ISSUE.
- ISSUE: fpu_start=1; clear watchdog; go to WAIT.
- WAIT:
  - fpu_start stays 1; watchdog increments each cycle.
  - On rising edge of fpu_cmd_end (registered compare): capture fpu_result into rsp_data, rsp_err=0, fpu_start=0, go to RESP.
  - Else if watchdog == TIMEOUT_CYCLES-1: rsp_data=NAN_VALUE, rsp_err=1, fpu_start=0, go to RESP.
  - If cmd_end and timeout coincide, cmd_end wins.
- RESP: rsp_valid[owner]=1 for one cycle; last=owner; go to IDLE.
- Latency: gnt→fpu_start = 1 cycle. cmd_end rise (sampled)→rsp_valid = 2 cycles. Minimum back-to-back spacing = 4 cycles plus FPU time.
- req deasserted while in ISSUE/WAIT/RESP has no effect; the response is still delivered.
- A requester may re-request in the cycle after its gnt, but is not granted again while other requesters are pending (fairness).
- fpu_a/b/operation stay stable from ISSUE until the next grant.
- rsp_data holds its value until the next RESP.
- req with no matching data change after gnt is ignored; there is exactly one gnt per transaction.

Test Plan:
- Single op: req[0] with a=32'h41800000, b=32'h42000000, op=op_add → gnt[0] pulse; fpu_start high until cmd_end; rsp_valid[0] with rsp_data=32'h42400000, rsp_err=0.
- Contention: req[0..3] all asserted with a/b=0.25/0.5 (3E800000/3F000000) op_add → grants in order 0,1,2,3; each rsp_data=32'h3F400000; exactly one rsp_valid per requester.
- Fairness: req[1] held continuously, req[2] asserted after the first grant → grant order 1,2,1 (never 1,1).
- Timeout: FPU model with cmd_end tied low, TIMEOUT_CYCLES=8 → fpu_start falls 8 cycles after rising; rsp_valid with rsp_data=32'h7FC00000, rsp_err=1; next req serviced normally.
- FPU busy gating: fpu_busy=1 while req[0]=1 → no gnt until fpu_busy=0, then gnt on the next edge.
- Reset mid-op: drive arst=0 while in WAIT → fpu_start=0 immediately; no rsp_valid; after release, req[0] is granted first.

Source files
------------

// File: rtl/pa_fpu.sv
// Shared FPU type definitions used by the FPU and its front-end arbiter.
package pa_fpu;

  typedef enum logic [2:0] {
    op_add,
    op_sub,
    op_mul,
    op_div,
    op_sqrt,
    op_cmp,
    op_i2f,
    op_f2i
  } e_fpu_op;

endpackage

// File: rtl/fpu_arbiter.sv
// Round-robin front end that shares one FPU between NUM_REQ requesters,
// drives the start/cmd_end handshake and aborts hung operations via a watchdog.
module fpu_arbiter #(
  parameter int unsigned NUM_REQ        = 4,
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter logic [31:0] NAN_VALUE      = 32'h7FC00000
) (
  input  logic                                      clk,
  input  logic                                      arst,
  input  logic [NUM_REQ-1:0]                        req,
  input  logic [32*NUM_REQ-1:0]                     req_a,
  input  logic [32*NUM_REQ-1:0]                     req_b,
  input  logic [$bits(pa_fpu::e_fpu_op)*NUM_REQ-1:0] req_op,
  output logic [NUM_REQ-1:0]                        gnt,
  output logic [NUM_REQ-1:0]                        rsp_valid,
  output logic [31:0]                               rsp_data,
  output logic                                      rsp_err,
  output logic                                      fpu_start,
  output logic [31:0]                               fpu_a_operand,
  output logic [31:0]                               fpu_b_operand,
  output pa_fpu::e_fpu_op                           fpu_operation,
  input  logic [31:0]                               fpu_result,
  input  logic                                      fpu_cmd_end,
  input  logic                                      fpu_busy,
  output logic                                      arb_busy
);

  localparam int unsigned OpW  = $bits(pa_fpu::e_fpu_op);
  localparam int unsigned IdxW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned WdW  = $clog2(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

  state_e               state;
  logic [IdxW-1:0]      last;
  logic [IdxW-1:0]      owner;
  logic [WdW-1:0]       wd;
  logic                 cmd_end_q;

  logic                 win_found;
  logic [IdxW-1:0]      win_idx;
  logic [IdxW-1:0]      cand;
  logic [31:0]          win_a;
  logic [31:0]          win_b;
  pa_fpu::e_fpu_op      win_op;

  // Scan last+1, last+2, ... so the most recent owner has lowest priority.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      cand = IdxW'((32'(last) + k) % NUM_REQ);
      if (!win_found && req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
    win_a  = '0;
    win_b  = '0;
    win_op = pa_fpu::e_fpu_op'(0);
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (win_idx == IdxW'(i)) begin
        win_a  = req_a[32*i +: 32];
        win_b  = req_b[32*i +: 32];
        win_op = pa_fpu::e_fpu_op'(req_op[OpW*i +: OpW]);
      end
    end
  end

  always_ff @(posedge clk or negedge arst) begin
    if (!arst) begin
      state         <= StIdle;
      last          <= IdxW'(NUM_REQ - 1);
      owner         <= '0;
      wd            <= '0;
      cmd_end_q     <= 1'b0;
      gnt           <= '0;
      rsp_valid     <= '0;
      rsp_data      <= '0;
      rsp_err       <= 1'b0;
      fpu_start     <= 1'b0;
      fpu_a_operand <= '0;
      fpu_b_operand <= '0;
      fpu_operation <= pa_fpu::e_fpu_op'(0);
    end else begin
      gnt       <= '0;
      rsp_valid <= '0;
      cmd_end_q <= fpu_cmd_end;
      unique case (state)
        StIdle: begin
          if (win_found && !fpu_busy && !fpu_cmd_end) begin
            fpu_a_operand <= win_a;
            fpu_b_operand <= win_b;
            fpu_operation <= win_op;
            owner         <= win_idx;
            gnt[win_idx]  <= 1'b1;
            state         <= StIssue;
          end
        end
        StIssue: begin
          fpu_start <= 1'b1;
          wd        <= '0;
          state     <= StWait;
        end
        StWait: begin
          wd <= wd + 1'b1;
          // A completion in the same cycle as the timeout still delivers real data.
          if (fpu_cmd_end && !cmd_end_q) begin
            rsp_data  <= fpu_result;
            rsp_err   <= 1'b0;
            fpu_start <= 1'b0;
            state     <= StResp;
          end else if (wd == WdW'(TIMEOUT_CYCLES - 1)) begin
            rsp_data  <= NAN_VALUE;
            rsp_err   <= 1'b1;
            fpu_start <= 1'b0;
            state     <= StResp;
          end
        end
        StResp: begin
          rsp_valid[owner] <= 1'b1;
          last             <= owner;
          state            <= StIdle;
        end
        default: state <= StIdle;
      endcase
    end
  end

  assign arb_busy = (state != StIdle);

endmodule

// File: tb/tb_fpu_arbiter.sv
// Self-checking bench for fpu_arbiter: vector table, directed corner sequences
// and a randomized run against a round-robin scoreboard with a stub FPU.
module tb_fpu_arbiter;

  localparam int N = 4;

  logic            clk = 1'b0;
  logic            arst;
  logic [N-1:0]    req;
  logic [32*N-1:0] req_a;
  logic [32*N-1:0] req_b;
  logic [3*N-1:0]  req_op;
  logic [N-1:0]    gnt;
  logic [N-1:0]    rsp_valid;
  logic [31:0]     rsp_data;
  logic            rsp_err;
  logic            fpu_start;
  logic [31:0]     fpu_a_operand;
  logic [31:0]     fpu_b_operand;
  pa_fpu::e_fpu_op fpu_operation;
  logic [31:0]     fpu_result;
  logic            fpu_cmd_end;
  logic            fpu_busy;
  logic            arb_busy;

  logic [31:0] ra [N];
  logic [31:0] rb [N];
  logic [2:0]  rop[N];

  logic hang;
  int   lat;
  int   n_total = 0;
  int   n_pass  = 0;

  fpu_arbiter #(
    .NUM_REQ       (N),
    .TIMEOUT_CYCLES(8),
    .NAN_VALUE     (32'h7FC00000)
  ) dut (
    .clk          (clk),
    .arst         (arst),
    .req          (req),
    .req_a        (req_a),
    .req_b        (req_b),
    .req_op       (req_op),
    .gnt          (gnt),
    .rsp_valid    (rsp_valid),
    .rsp_data     (rsp_data),
    .rsp_err      (rsp_err),
    .fpu_start    (fpu_start),
    .fpu_a_operand(fpu_a_operand),
    .fpu_b_operand(fpu_b_operand),
    .fpu_operation(fpu_operation),
    .fpu_result   (fpu_result),
    .fpu_cmd_end  (fpu_cmd_end),
    .fpu_busy     (fpu_busy),
    .arb_busy     (arb_busy)
  );

  always #5 clk = ~clk;

  always_comb begin
    req_a  = '0;
    req_b  = '0;
    req_op = '0;
    for (int i = 0; i < N; i++) begin
      req_a[32*i +: 32] = ra[i];
      req_b[32*i +: 32] = rb[i];
      req_op[3*i +: 3]  = rop[i];
    end
  end

  // Stub FPU: known results for the plan's vectors, a fixed mix otherwise.
  function automatic logic [31:0] fpu_stub(input logic [31:0] a, input logic [31:0] b,
                                           input logic [2:0] op);
    if (op == 3'd0 && a == 32'h41800000 && b == 32'h42000000) return 32'h42400000;
    if (op == 3'd0 && a == 32'h3E800000 && b == 32'h3F000000) return 32'h3F400000;
    return a ^ {b[15:0], b[31:16]} ^ {29'd0, op};
  endfunction

  logic start_d;
  int   fcnt;
  always @(posedge clk or negedge arst) begin
    if (!arst) begin
      start_d     <= 1'b0;
      fcnt        <= 0;
      fpu_cmd_end <= 1'b0;
      fpu_result  <= '0;
    end else begin
      start_d     <= fpu_start;
      fpu_cmd_end <= 1'b0;
      if (fpu_start && !start_d) begin
        fcnt <= lat;
      end else if (fcnt > 0) begin
        fcnt <= fcnt - 1;
        if (fcnt == 1 && !hang) begin
          fpu_cmd_end <= 1'b1;
          fpu_result  <= fpu_stub(fpu_a_operand, fpu_b_operand, fpu_operation);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic fail_now(input string name);
    n_total++;
    $display("FAIL %s: wait bound expired, got nothing expected event", name);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_gnt(input string name, output logic [N-1:0] g);
    g = '0;
    for (int k = 0; k < 100; k++) begin
      step();
      if (gnt != '0) begin
        g = gnt;
        return;
      end
    end
    fail_now(name);
  endtask

  task automatic wait_rsp(input string name);
    for (int k = 0; k < 100; k++) begin
      step();
      if (rsp_valid != '0) return;
    end
    fail_now(name);
  endtask

  task automatic reset_dut();
    arst     = 1'b0;
    req      = '0;
    hang     = 1'b0;
    fpu_busy = 1'b0;
    lat      = 2;
    repeat (2) step();
    arst = 1'b1;
    step();
  endtask

  typedef struct {
    logic [N-1:0] rq;
    logic [31:0]  a;
    logic [31:0]  b;
    logic [2:0]   op;
    logic [N-1:0] exp_gnt;
    logic [31:0]  exp_data;
  } vec_t;

  vec_t vecs[4];

  initial begin
    logic [N-1:0] g;
    logic [N-1:0] acc;
    int           idx;
    int           cnt;

    vecs[0] = '{4'b0001, 32'h41800000, 32'h42000000, 3'd0, 4'b0001, 32'h42400000};
    vecs[1] = '{4'b0100, 32'h3E800000, 32'h3F000000, 3'd0, 4'b0100, 32'h3F400000};
    vecs[2] = '{4'b1000, 32'h12345678, 32'h9ABCDEF0, 3'd2, 4'b1000, 32'hCCC4CCC6};
    vecs[3] = '{4'b0010, 32'h00000000, 32'h00000001, 3'd3, 4'b0010, 32'h00010003};

    for (int i = 0; i < N; i++) begin
      ra[i] = '0; rb[i] = '0; rop[i] = '0;
    end
    arst = 1'b0; req = '0; hang = 1'b0; fpu_busy = 1'b0; lat = 2;
    #3;
    check("rst_gnt", gnt, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_err", rsp_err, 0);
    check("rst_rsp_data", rsp_data, 0);
    check("rst_fpu_start", fpu_start, 0);
    check("rst_arb_busy", arb_busy, 0);
    check("rst_fpu_a", fpu_a_operand, 0);
    check("rst_fpu_op", fpu_operation, 0);
    reset_dut();

    // Vector table: single-requester transactions.
    foreach (vecs[v]) begin
      idx = 0;
      for (int j = 0; j < N; j++) if (vecs[v].rq[j]) idx = j;
      ra[idx] = vecs[v].a; rb[idx] = vecs[v].b; rop[idx] = vecs[v].op;
      req = vecs[v].rq;
      wait_gnt("vec_gnt_wait", g);
      check("vec_gnt", g, vecs[v].exp_gnt);
      req = '0;
      step();
      check("vec_start_latency", fpu_start, 1);
      check("vec_op_latched", {fpu_a_operand ^ fpu_b_operand}, vecs[v].a ^ vecs[v].b);
      wait_rsp("vec_rsp_wait");
      check("vec_rsp_valid", rsp_valid, vecs[v].exp_gnt);
      check("vec_rsp_data", rsp_data, vecs[v].exp_data);
      check("vec_rsp_err", rsp_err, 0);
      check("vec_start_low", fpu_start, 0);
      step();
      check("vec_rsp_pulse", rsp_valid, 0);
      check("vec_data_hold", rsp_data, vecs[v].exp_data);
    end

    // Contention: grants 0,1,2,3 after reset.
    reset_dut();
    for (int i = 0; i < N; i++) begin
      ra[i] = 32'h3E800000; rb[i] = 32'h3F000000; rop[i] = 3'd0;
    end
    req = 4'b1111;
    for (int k = 0; k < N; k++) begin
      wait_gnt("cont_gnt_wait", g);
      check("cont_gnt", g, 4'b0001 << k);
      req = req & ~g;
      acc = '0;
      cnt = 0;
      wait_rsp("cont_rsp_wait");
      check("cont_rsp_valid", rsp_valid, 4'b0001 << k);
      check("cont_rsp_data", rsp_data, 32'h3F400000);
    end
    repeat (10) begin
      step();
      acc |= rsp_valid | gnt;
    end
    check("cont_no_extra", acc, 0);

    // Fairness: req[1] held, req[2] joins after first grant.
    reset_dut();
    req = 4'b0010;
    wait_gnt("fair_gnt_wait", g);
    check("fair_gnt0", g, 4'b0010);
    req = 4'b0110;
    wait_gnt("fair_gnt_wait", g);
    check("fair_gnt1", g, 4'b0100);
    req = 4'b0010;
    wait_gnt("fair_gnt_wait", g);
    check("fair_gnt2", g, 4'b0010);
    req = '0;
    wait_rsp("fair_rsp_wait");

    // Timeout: FPU never completes.
    reset_dut();
    hang = 1'b1;
    ra[0] = 32'h1; rb[0] = 32'h2; rop[0] = 3'd1;
    req = 4'b0001;
    wait_gnt("to_gnt_wait", g);
    req = '0;
    step();
    check("to_start_rise", fpu_start, 1);
    cnt = 0;
    while (fpu_start && cnt < 50) begin
      step();
      cnt++;
    end
    check("to_start_width", cnt, 8);
    wait_rsp("to_rsp_wait");
    check("to_rsp_valid", rsp_valid, 4'b0001);
    check("to_rsp_data", rsp_data, 32'h7FC00000);
    check("to_rsp_err", rsp_err, 1);
    hang = 1'b0;
    ra[3] = 32'hA5A5A5A5; rb[3] = 32'h0F0F0000; rop[3] = 3'd4;
    req = 4'b1000;
    wait_gnt("to_next_gnt_wait", g);
    check("to_next_gnt", g, 4'b1000);
    req = '0;
    wait_rsp("to_next_rsp_wait");
    check("to_next_data", rsp_data, fpu_stub(32'hA5A5A5A5, 32'h0F0F0000, 3'd4));
    check("to_next_err", rsp_err, 0);

    // Busy gating.
    reset_dut();
    fpu_busy = 1'b1;
    req = 4'b0001;
    acc = '0;
    repeat (6) begin
      step();
      acc |= gnt;
    end
    check("busy_no_gnt", acc, 0);
    fpu_busy = 1'b0;
    step();
    check("busy_gnt_after", gnt, 4'b0001);
    req = '0;
    wait_rsp("busy_rsp_wait");

    // Reset while waiting on the FPU.
    reset_dut();
    hang = 1'b1;
    req = 4'b0001;
    wait_gnt("rmid_gnt_wait", g);
    req = '0;
    repeat (3) step();
    check("rmid_start_before", fpu_start, 1);
    #2 arst = 1'b0;
    #1;
    check("rmid_start_drop", fpu_start, 0);
    check("rmid_busy_drop", arb_busy, 0);
    acc = '0;
    repeat (3) begin
      step();
      acc |= rsp_valid;
    end
    arst = 1'b1;
    hang = 1'b0;
    repeat (12) begin
      step();
      acc |= rsp_valid;
    end
    check("rmid_no_rsp", acc, 0);
    req = 4'b0101;
    wait_gnt("rmid_regnt_wait", g);
    check("rmid_first_gnt", g, 4'b0001);
    req = 4'b0100;
    wait_gnt("rmid_second_wait", g);
    req = '0;
    wait_rsp("rmid_rsp_wait");

    // Randomized run against a round-robin scoreboard.
    begin
      int           model_last;
      int           own;
      int           exp_w;
      int           c;
      int           n_gnt;
      int           n_rsp;
      int           wait_cnt[N];
      bit           inflight;
      bit           chk_ops;
      logic [31:0]  ea;
      logic [31:0]  eb;
      logic [2:0]   eop;
      logic [31:0]  edata;
      logic [N-1:0] seen;

      reset_dut();
      model_last = N - 1;
      own = 0;
      inflight = 1'b0;
      chk_ops = 1'b0;
      n_gnt = 0;
      n_rsp = 0;
      ea = '0; eb = '0; eop = '0; edata = '0;
      for (int i = 0; i < N; i++) wait_cnt[i] = 0;
      for (int cyc = 0; cyc < 3000; cyc++) begin
        step();
        seen = req;
        if (chk_ops) begin
          check("rnd_ops", {fpu_a_operand ^ {fpu_b_operand[30:0], fpu_b_operand[31]}},
                ea ^ {eb[30:0], eb[31]});
          check("rnd_op", fpu_operation, eop);
          chk_ops = 1'b0;
        end
        if (rsp_valid != '0) begin
          check("rnd_rsp_owner", rsp_valid, inflight ? (4'b0001 << own) : 4'b0000);
          check("rnd_rsp_data", rsp_data, edata);
          check("rnd_rsp_err", rsp_err, 0);
          inflight = 1'b0;
          model_last = own;
          n_rsp++;
        end
        if (gnt != '0) begin
          exp_w = -1;
          for (int k = 1; k <= N; k++) begin
            c = (model_last + k) % N;
            if (seen[c] && exp_w < 0) exp_w = c;
          end
          check("rnd_gnt", gnt, (exp_w < 0) ? 4'b0000 : (4'b0001 << exp_w));
          check("rnd_overlap", inflight, 0);
          if (exp_w >= 0) begin
            own = exp_w;
            ea = ra[own]; eb = rb[own]; eop = rop[own];
            edata = fpu_stub(ea, eb, eop);
            req[own] = 1'b0;
          end
          inflight = 1'b1;
          chk_ops = 1'b1;
          n_gnt++;
          lat = $urandom_range(1, 6);
        end
        for (int i = 0; i < N; i++) begin
          wait_cnt[i] = req[i] ? wait_cnt[i] + 1 : 0;
          if (wait_cnt[i] > 150) begin
            fail_now("rnd_starvation");
            wait_cnt[i] = 0;
          end
          if (!req[i] && $urandom_range(0, 3) == 0) begin
            ra[i] = $urandom; rb[i] = $urandom; rop[i] = 3'($urandom_range(0, 7));
            req[i] = 1'b1;
          end
        end
      end
      req = '0;
      for (int k = 0; k < 60 && inflight; k++) begin
        step();
        if (rsp_valid != '0) begin
          check("rnd_drain_data", rsp_data, edata);
          inflight = 1'b0;
          n_rsp++;
        end
      end
      check("rnd_gnt_rsp_balance", n_rsp, n_gnt);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
